// File: rtl/wb_arb_pkg.sv
// Shared encodings for the dual-master Wishbone arbiter: FSM state codes and
// the one-hot grant vector layout ({m1,m0}).
package wb_arb_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_BUSY_M0 = 2'd1;
  localparam logic [1:0] ARB_BUSY_M1 = 2'd2;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_timeout.sv
// Per-transaction watchdog: counts BUSY cycles without an acknowledge and
// flags the last permitted cycle. TIMEOUT_CYCLES=0 makes it inert.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_WIDTH   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_WIDTH-1:0] TERM =
    TO_EN ? TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturates at TERM so a stalled BUSY state can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (TO_EN && enable && (cnt_q != TERM)) begin
      cnt_d = cnt_q + TO_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = TO_EN && (cnt_q == TERM);

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave between the
// instruction-side (m0) and data-side (m1) bridges, one transaction per grant.
//
// state       | meaning
// ARB_IDLE    | no grant; slave outputs held at zero, turnaround cycle
// ARB_BUSY_M0 | m0 owns the slave until ack, abort or timeout
// ARB_BUSY_M1 | m1 owns the slave until ack, abort or timeout
module wb_dual_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack,
  output logic                    m0_err,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack,
  output logic                    m1_err,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack,

  output logic [1:0]              grant_o
);

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;

  logic req0, req1;
  logic busy_m0, busy_m1, busy;

  logic                    g_cyc, g_stb, g_we;
  logic [DATA_WIDTH/8-1:0] g_sel;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_wdata;

  logic expired, timeout_hit, ack_hit;

  assign req0    = m0_cyc & m0_stb;
  assign req1    = m1_cyc & m1_stb;
  assign busy_m0 = (state_q == ARB_BUSY_M0);
  assign busy_m1 = (state_q == ARB_BUSY_M1);
  assign busy    = busy_m0 | busy_m1;

  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_sel   = '0;
    g_addr  = '0;
    g_wdata = '0;
    if (busy_m0) begin
      g_cyc   = m0_cyc;
      g_stb   = m0_stb;
      g_we    = m0_we;
      g_sel   = m0_sel;
      g_addr  = m0_addr;
      g_wdata = m0_data_i;
    end else if (busy_m1) begin
      g_cyc   = m1_cyc;
      g_stb   = m1_stb;
      g_we    = m1_we;
      g_sel   = m1_sel;
      g_addr  = m1_addr;
      g_wdata = m1_data_i;
    end
  end

  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_WIDTH   (TO_CNT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~busy),
    .enable  (busy & ~s_ack),
    .expired (expired)
  );

  // An ack in the terminal cycle beats the timeout; a dropped cyc beats both.
  assign ack_hit     = g_cyc & s_ack;
  assign timeout_hit = g_cyc & expired & ~s_ack;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = ARB_BUSY_M0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = ARB_BUSY_M1;
          last_grant_d = 1'b1;
        end
      end
      ARB_BUSY_M0, ARB_BUSY_M1: begin
        if (!g_cyc || s_ack || expired) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign s_cyc    = g_cyc & ~timeout_hit;
  assign s_stb    = g_cyc & g_stb & ~timeout_hit;
  assign s_we     = g_we;
  assign s_sel    = g_sel;
  assign s_addr   = g_addr;
  assign s_data_o = g_wdata;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign m0_ack    = busy_m0 & ack_hit;
  assign m1_ack    = busy_m1 & ack_hit;
  assign m0_err    = busy_m0 & timeout_hit;
  assign m1_err    = busy_m1 & timeout_hit;

  assign grant_o = busy_m0 ? GRANT_M0 : (busy_m1 ? GRANT_M1 : GRANT_NONE);

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Scoreboard bench for wb_dual_master_arbiter with an 8-cycle timeout and a
// registered slave model whose ack latency is set per test.
module tb_wb_dual_master_arbiter;

  typedef struct packed {
    logic [3:0]  flags;   // {m1_err, m1_ack, m0_err, m0_ack}
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        scyc;
    logic [7:0]  bc;      // BUSY cycle index in which the response appears
  } ev_t;

  logic        clk, rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_data_i, m0_data_o;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_data_i, m1_data_o;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_data_o, s_data_i;
  logic [1:0]  grant_o;

  int          total = 0;
  int          bad   = 0;
  int          seen  = 0;
  ev_t         exp_q[$];
  int          ack_delay = 1;
  logic [31:0] rdata = '0;
  bit          stray_req = 1'b0;

  wb_dual_master_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .TO_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_addr(s_addr), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack(s_ack), .grant_o(grant_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_ack(input int m, input logic [31:0] a, input logic we,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input logic [31:0] rd, input int b);
    ev_t e;
    e.flags = (m == 0) ? 4'b0001 : 4'b0100;
    e.rdata = rd;
    e.addr  = a;
    e.we    = we;
    e.sel   = sel;
    e.wdata = wd;
    e.scyc  = 1'b1;
    e.bc    = 8'(b);
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int m, input int b);
    ev_t e;
    e       = '0;
    e.flags = (m == 0) ? 4'b0010 : 4'b1000;
    e.scyc  = 1'b0;
    e.bc    = 8'(b);
    exp_q.push_back(e);
  endtask

  // Slave: acks when it has seen ack_delay BUSY cycles already in this grant.
  initial begin
    int scnt;
    scnt = 0;
    s_ack = 1'b0;
    s_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (grant_o != 2'b00) begin
        s_ack = (scnt == ack_delay);
        s_data_i = s_ack ? rdata : '0;
        scnt++;
      end else begin
        scnt = 0;
        s_ack = stray_req;
        stray_req = 1'b0;
        s_data_i = '0;
      end
    end
  end

  // Monitor: every ack/err seen by a master is matched against the queue.
  initial begin
    int bc;
    ev_t e;
    logic [3:0]  flags;
    logic [31:0] rd;
    bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || grant_o == 2'b00) bc = 0;
      else bc++;
      flags = {m1_err, m1_ack, m0_err, m0_ack};
      if (flags != 4'b0000) begin
        rd = (m1_ack | m1_err) ? m1_data_o : m0_data_o;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got flags %b expected none at %0t", flags, $time);
        end else begin
          e = exp_q.pop_front();
          chk("ev_flags", 32'(flags), 32'(e.flags));
          chk("ev_busy_cycle", 32'(bc), 32'(e.bc));
          chk("ev_s_cyc", 32'(s_cyc), 32'(e.scyc));
          if (e.flags[0] || e.flags[2]) begin
            chk("ev_rdata", rd, e.rdata);
            chk("ev_s_addr", s_addr, e.addr);
            chk("ev_s_we", 32'(s_we), 32'(e.we));
            chk("ev_s_sel", 32'(s_sel), 32'(e.sel));
            chk("ev_s_data_o", s_data_o, e.wdata);
          end
        end
        seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic on, input logic [31:0] a, input logic we,
                        input logic [3:0] sel, input logic [31:0] wd);
    m0_cyc = on; m0_stb = on; m0_addr = a; m0_we = we; m0_sel = sel; m0_data_i = wd;
  endtask

  task automatic set_m1(input logic on, input logic [31:0] a, input logic we,
                        input logic [3:0] sel, input logic [31:0] wd);
    m1_cyc = on; m1_stb = on; m1_addr = a; m1_we = we; m1_sel = sel; m1_data_i = wd;
  endtask

  // Returns 1 ns after the clock edge that closes the cycle of the target event.
  task automatic wait_events(input int target, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (seen >= target) break;
      @(posedge clk);
    end
    #1;
    chk(nm, 32'(seen), 32'(target));
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_grant"}, 32'(grant_o), 32'h0);
    chk({pfx, "_s_cyc"}, 32'(s_cyc), 32'h0);
    chk({pfx, "_s_stb"}, 32'(s_stb), 32'h0);
    chk({pfx, "_s_we"}, 32'(s_we), 32'h0);
    chk({pfx, "_s_sel"}, 32'(s_sel), 32'h0);
    chk({pfx, "_s_addr"}, s_addr, 32'h0);
    chk({pfx, "_s_data_o"}, s_data_o, 32'h0);
    chk({pfx, "_acks_errs"}, 32'({m1_err, m1_ack, m0_err, m0_ack}), 32'h0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    set_m0(1'b0, '0, 1'b0, '0, '0);
    set_m1(1'b0, '0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Both masters request continuously from reset: strict m0/m1 alternation.
    base = seen;
    rdata = 32'h5A5A_0001;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_ack(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h5A5A_0001, 2);
      else            push_ack(1, 32'h2000_0000, 1'b0, 4'hF, 32'h0, 32'h5A5A_0001, 2);
    end
    set_m0(1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    set_m1(1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'h0);
    wait_events(base + 8, 100, "rr_event_count");
    set_m0(1'b0, '0, 1'b0, '0, '0);
    set_m1(1'b0, '0, 1'b0, '0, '0);
    tick();

    // Single m0 read with grant timing.
    base = seen;
    rdata = 32'hDEAD_BEEF;
    push_ack(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 2);
    set_m0(1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t1_grant_before_edge", 32'(grant_o), 32'h0);
    @(negedge clk);
    chk("t1_grant_busy", 32'(grant_o), 32'h1);
    chk("t1_s_stb", 32'(s_stb), 32'h1);
    chk("t1_s_addr", s_addr, 32'h0000_0100);
    wait_events(base + 1, 20, "t1_event_count");
    set_m0(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_grant_turnaround", 32'(grant_o), 32'h0);
    chk("t1_m1_ack", 32'(m1_ack), 32'h0);
    tick();

    // m1 write.
    base = seen;
    rdata = 32'h0;
    push_ack(1, 32'h2000_0010, 1'b1, 4'b0011, 32'h1234_5678, 32'h0, 2);
    set_m1(1'b1, 32'h2000_0010, 1'b1, 4'b0011, 32'h1234_5678);
    wait_events(base + 1, 20, "t3_event_count");
    set_m1(1'b0, '0, 1'b0, '0, '0);
    tick();

    // m0 never acked -> err on 8th BUSY cycle; pending m1 served afterwards.
    base = seen;
    ack_delay = 99;
    rdata = 32'h7777_0004;
    push_err(0, 8);
    push_ack(1, 32'h2000_0020, 1'b0, 4'hF, 32'h0, 32'h7777_0004, 2);
    set_m0(1'b1, 32'h0000_0120, 1'b0, 4'hF, 32'h0);
    set_m1(1'b1, 32'h2000_0020, 1'b0, 4'hF, 32'h0);
    wait_events(base + 1, 30, "t4_err_count");
    set_m0(1'b0, '0, 1'b0, '0, '0);
    ack_delay = 1;
    @(negedge clk);
    chk("t4_grant_turnaround", 32'(grant_o), 32'h0);
    chk("t4_s_cyc_idle", 32'(s_cyc), 32'h0);
    wait_events(base + 2, 20, "t4_m1_count");
    set_m1(1'b0, '0, 1'b0, '0, '0);
    tick();

    // Ack in the terminal timeout cycle wins; then a stray ack while idle.
    base = seen;
    ack_delay = 7;
    rdata = 32'hCAFE_F00D;
    push_ack(0, 32'h0000_0140, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 8);
    set_m0(1'b1, 32'h0000_0140, 1'b0, 4'hF, 32'h0);
    wait_events(base + 1, 30, "t5_event_count");
    set_m0(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    stray_req = 1'b1;
    @(negedge clk);
    chk("t5_stray_m0_ack", 32'(m0_ack), 32'h0);
    chk("t5_stray_m1_ack", 32'(m1_ack), 32'h0);
    chk("t5_stray_grant", 32'(grant_o), 32'h0);
    tick();
    ack_delay = 1;

    // Asynchronous reset in the middle of an m1 transfer.
    ack_delay = 99;
    set_m1(1'b1, 32'h2000_0030, 1'b0, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    chk("t6_grant_m1", 32'(grant_o), 32'h2);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    set_m1(1'b0, '0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    tick();
    rst_n = 1'b1;
    ack_delay = 1;
    rdata = 32'h0BAD_F00D;
    base = seen;
    push_ack(0, 32'h0000_0180, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 2);
    push_ack(1, 32'h2000_0040, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 2);
    set_m0(1'b1, 32'h0000_0180, 1'b0, 4'hF, 32'h0);
    set_m1(1'b1, 32'h2000_0040, 1'b0, 4'hF, 32'h0);
    wait_events(base + 2, 40, "t6_event_count");
    set_m0(1'b0, '0, 1'b0, '0, '0);
    set_m1(1'b0, '0, 1'b0, '0, '0);

    repeat (5) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
Shares one Wishbone classic slave port (controller memory port) between two Wishbone masters: m0 = instruction-side AHB-to-Wishbone bridge, m1 = data-side bridge. Used when the second memory is disabled and both core buses must reach a single memory.
Round-robin arbitration, one transaction per grant, with an optional per-transaction timeout that returns an error to a master whose transfer is never acknowledged.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports; sel width = DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, cycles in BUSY without s_ack before error; 0 disables timeout
TO_CNT_WIDTH, 16, timeout counter width; must satisfy TIMEOUT_CYCLES < 2**TO_CNT_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
m0_cyc/m0_stb/m0_we  in  1 each  master 0 cycle/strobe/write
m0_sel  in  DATA_WIDTH/8  master 0 byte selects
m0_addr  in  ADDR_WIDTH  master 0 address
m0_data_i  in  DATA_WIDTH  master 0 write data
m0_data_o  out  DATA_WIDTH  read data to master 0
m0_ack  out  1  ack to master 0
m0_err  out  1  timeout error to master 0
m1_*  (same set as m0_*)  master 1 (data bus)
s_cyc/s_stb/s_we  out  1 each  to slave
s_sel  out  DATA_WIDTH/8  to slave
s_addr  out  ADDR_WIDTH  to slave
s_data_o  out  DATA_WIDTH  write data to slave
s_data_i  in  DATA_WIDTH  read data from slave
s_ack  in  1  slave acknowledge
grant_o  out  2  one-hot current grant ({m1,m0}); 2'b00 when idle

Behaviour:
- Clocking: one clock, clk. Reset: asynchronous, active-low, rst_n.
- Request: reqN = mN_cyc & mN_stb.
- State machine (registered): IDLE, BUSY_M0, BUSY_M1. Registered last_grant (0=m0, 1=m1).
- IDLE:
  - only req0 -> BUSY_M0
  - only req1 -> BUSY_M1
  - both -> grant the master != last_grant
  - none -> stay
  - last_grant updates on entry to BUSY.
- BUSY_Mx, slave side: s_cyc/s_stb/s_we/s_sel/s_addr/s_data_o = granted master's signals (combinational mux from registered state). All slave outputs are 0 in IDLE.
- BUSY_Mx, ack path:
  - mx_ack = s_ack, same cycle (combinational).
  - On s_ack -> IDLE. There is one mandatory idle turnaround cycle before any next grant.
- Abort: granted master drops cyc while BUSY -> IDLE next cycle; s_cyc drops the same cycle (combinational); no ack forwarded.
- Stray acks: s_ack in IDLE is ignored. s_ack is never routed to the non-granted master.
- Read data: m0_data_o = m1_data_o = s_data_i always. Only the ack/err qualifies it.
- Timeout:
  - Counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When counter == TIMEOUT_CYCLES-1 and no s_ack: pulse mx_err for exactly that cycle, force s_cyc/s_stb low that cycle, -> IDLE.
  - s_ack in the same cycle wins: ack is given, err is not.
  - TIMEOUT_CYCLES=0: counter inert, err never asserted.
- Latency: request visible in IDLE at edge N -> slave strobe during cycle N+1. Minimum 3 cycles per transaction with a 1-cycle slave (grant, ack, turnaround).
- Fairness: under continuous requests from both masters, grants strictly alternate m0,m1,m0,...
- Reset values: state=IDLE, last_grant=1 (m0 wins first contention), counter=0. All outputs 0 (grant_o=00, acks/errs 0, s_* 0). Reset mid-transaction aborts immediately; no ack or err is emitted.
- Width rules: counter saturates at TIMEOUT_CYCLES-1, no wrap. mN_err and mN_ack are never both 1.

Decomposition:
- Shared package wb_arb_pkg: state encoding constants (ARB_IDLE=2'd0, ARB_BUSY_M0=2'd1, ARB_BUSY_M1=2'd2) and GRANT_NONE/GRANT_M0/GRANT_M1 one-hot constants.
- One natural sub-module: wb_arb_timeout (counter + compare: inputs clk, rst_n, clear, enable; output expired). All other logic stays in the top.

Test Plan:
1. Single m0 read; slave acks 1 cycle after strobe with s_data_i=32'hDEADBEEF -> m0_ack one cycle, m0_data_o=DEADBEEF, m1_ack=0, grant_o 01 then 00, one idle cycle.
2. m0 and m1 request from reset, both continuous, 1-cycle slave -> grants m0,m1,m0,m1 for 8 transactions; addresses at slave alternate (m0 0x100, m1 0x2000_0000).
3. m1 write addr 0x2000_0010, data 0x12345678, sel 4'b0011 -> s_we=1, s_addr/s_data_o/s_sel match exactly; m1_ack on s_ack.
4. TIMEOUT_CYCLES=8, slave never acks m0 -> m0_err pulses 1 cycle on the 8th BUSY cycle, s_cyc low that cycle, then IDLE; pending m1 granted after turnaround.
5. s_ack arrives in the final timeout cycle -> m0_ack=1, m0_err=0; a stray s_ack in IDLE -> no master ack.
6. rst_n low mid-BUSY_M1 -> all outputs 0 immediately (async); after release, contending requests grant m0 first.
